// File: rtl/vedic_seq_8x8.sv
// vedic_seq_8x8: sequential 8x8 unsigned multiplier built on one vedic_4x4 core.
// Each operand is split into nibbles; the four nibble products are pushed
// through the core one per cycle and shift-accumulated into a 16-bit result.
// Valid/ready on both sides. Optional build macro VEDIC_SEQ_ZERO_SKIP_EN
// short-circuits a zero operand straight to DONE on the accept edge.

// 2x2 vedic cell: crosswise partial products with a half-adder chain.
module vedic_2x2 (
  input  logic [1:0] a,
  input  logic [1:0] b,
  output logic [3:0] p
);
  logic t1, t2, t3, c1;
  assign t1   = a[1] & b[0];
  assign t2   = a[0] & b[1];
  assign t3   = a[1] & b[1];
  assign c1   = t1 & t2;
  assign p[0] = a[0] & b[0];
  assign p[1] = t1 ^ t2;
  assign p[2] = t3 ^ c1;
  assign p[3] = t3 & c1;
endmodule

// 4x4 vedic core: four 2x2 cells, outer/cross products summed with shifts.
module vedic_4x4 (
  input  logic [3:0] a,
  input  logic [3:0] b,
  output logic [7:0] p
);
  logic [3:0][3:0] q;

  // cell gi takes a-half gi[0] and b-half gi[1]
  for (genvar gi = 0; gi < 4; gi++) begin : g_cell
    vedic_2x2 u_cell (
      .a (gi[0] ? a[3:2] : a[1:0]),
      .b (gi[1] ? b[3:2] : b[1:0]),
      .p (q[gi])
    );
  end

  assign p = {4'b0, q[0]} + {2'b0, q[1], 2'b0} + {2'b0, q[2], 2'b0} + {q[3], 4'b0};
endmodule

module vedic_seq_8x8 #(
  parameter bit HOLD_LAST = 1'b1
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        in_valid,
  output logic        in_ready,
  input  logic [7:0]  a,
  input  logic [7:0]  b,
  output logic        out_valid,
  input  logic        out_ready,
  output logic [15:0] out_product,
  output logic        busy
);
  typedef enum logic [1:0] {IDLE, CALC, DONE} state_t;

  state_t      state;
  logic [1:0]  step;
  logic [7:0]  ra, rb;
  logic [15:0] acc;

  logic [3:0]  na, nb;
  logic [7:0]  pp;
  logic [1:0]  nsum;
  logic [3:0]  shamt;
  logic [15:0] pp_sh, acc_nxt;

  assign in_ready = (state == IDLE);
  assign busy     = (state != IDLE);

  // step[0] picks the ra nibble, step[1] the rb nibble; shift is 4 per high nibble
  assign na      = step[0] ? ra[7:4] : ra[3:0];
  assign nb      = step[1] ? rb[7:4] : rb[3:0];
  assign nsum    = {1'b0, step[0]} + {1'b0, step[1]};
  assign shamt   = {nsum, 2'b00};
  assign pp_sh   = {8'b0, pp} << shamt;
  assign acc_nxt = acc + pp_sh;

  vedic_4x4 u_core (
    .a (na),
    .b (nb),
    .p (pp)
  );

  // control FSM plus accumulator and registered outputs
  always_ff @(posedge clk) begin
    if (rst) begin
      state       <= IDLE;
      step        <= 2'd0;
      ra          <= 8'd0;
      rb          <= 8'd0;
      acc         <= 16'd0;
      out_valid   <= 1'b0;
      out_product <= 16'd0;
    end else begin
      case (state)
        IDLE: begin
          if (in_valid) begin
            ra    <= a;
            rb    <= b;
            acc   <= 16'd0;
            step  <= 2'd0;
`ifdef VEDIC_SEQ_ZERO_SKIP_EN
            if (a == 8'd0 || b == 8'd0) begin
              out_product <= 16'd0;
              out_valid   <= 1'b1;
              state       <= DONE;
            end else begin
              state <= CALC;
            end
`else
            state <= CALC;
`endif
          end
        end
        CALC: begin
          acc  <= acc_nxt;
          step <= step + 2'd1;
          if (step == 2'd3) begin
            out_product <= acc_nxt;
            out_valid   <= 1'b1;
            state       <= DONE;
          end
        end
        DONE: begin
          if (out_ready) begin
            out_valid <= 1'b0;
            state     <= IDLE;
            if (!HOLD_LAST) out_product <= 16'd0;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end
endmodule

// File: tb/tb_vedic_seq_8x8.sv
// tb_vedic_seq_8x8: table vectors, hand-written corner sequences and random
// operands checked against plain a*b. Second instance covers HOLD_LAST=0.
module tb_vedic_seq_8x8;
  logic        clk = 1'b0;
  logic        rst;
  logic        in_valid, in_ready, out_valid, out_ready, busy;
  logic [7:0]  a, b;
  logic [15:0] out_product;

  logic        h_in_valid, h_in_ready, h_out_valid, h_out_ready, h_busy;
  logic [7:0]  h_a, h_b;
  logic [15:0] h_out_product;

  int tests = 0;
  int fails = 0;

  always #5 clk = ~clk;

  vedic_seq_8x8 #(.HOLD_LAST(1'b1)) dut (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready),
    .a(a), .b(b), .out_valid(out_valid), .out_ready(out_ready),
    .out_product(out_product), .busy(busy)
  );

  vedic_seq_8x8 #(.HOLD_LAST(1'b0)) dut_h0 (
    .clk(clk), .rst(rst), .in_valid(h_in_valid), .in_ready(h_in_ready),
    .a(h_a), .b(h_b), .out_valid(h_out_valid), .out_ready(h_out_ready),
    .out_product(h_out_product), .busy(h_busy)
  );

  typedef struct {
    logic [7:0]  a;
    logic [7:0]  b;
    logic [15:0] p;
  } vec_t;

  task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", nm, act, exp);
    end
  endtask

  function automatic int exp_lat(input logic [7:0] x, input logic [7:0] y);
`ifdef VEDIC_SEQ_ZERO_SKIP_EN
    if (x == 8'd0 || y == 8'd0) return 0;
`endif
    return 4;
  endfunction

  // one full transaction on dut; edges counted after the accept edge
  task automatic run_op(input string nm, input logic [7:0] x, input logic [7:0] y,
                        input logic [15:0] expv, input int stall, input bit inject);
    int k;
    k = 0;
    while (!in_ready && k < 20) begin @(negedge clk); k++; end
    check({nm, ".ready_wait"}, 32'(in_ready), 32'd1);
    in_valid  = 1'b1;
    a         = x;
    b         = y;
    out_ready = (stall == 0);
    @(negedge clk);
    in_valid = 1'b0;
    a = 8'hxx & 8'h00;
    b = 8'h5a;
    k = 0;
    while (!out_valid && k < 20) begin @(negedge clk); k++; end
    check({nm, ".latency"}, 32'(k), 32'(exp_lat(x, y)));
    check({nm, ".product"}, 32'(out_product), 32'(expv));
    for (int i = 0; i < stall; i++) begin
      if (inject && i == 1) begin in_valid = 1'b1; a = 8'h01; b = 8'h01; end
      else in_valid = 1'b0;
      @(negedge clk);
      check({nm, ".stall_valid"}, 32'(out_valid), 32'd1);
      check({nm, ".stall_prod"}, 32'(out_product), 32'(expv));
      check({nm, ".stall_inrdy"}, 32'(in_ready), 32'd0);
    end
    in_valid  = 1'b0;
    out_ready = 1'b1;
    @(negedge clk);
    out_ready = 1'b0;
    check({nm, ".post_valid"}, 32'(out_valid), 32'd0);
    check({nm, ".post_inrdy"}, 32'(in_ready), 32'd1);
    check({nm, ".post_hold"}, 32'(out_product), 32'(expv));
  endtask

  vec_t tbl[10];

  initial begin
    int k;
    logic [7:0] rx, ry;
    tbl[0] = '{8'h12, 8'h34, 16'h03A8};
    tbl[1] = '{8'hFF, 8'hFF, 16'hFE01};
    tbl[2] = '{8'h80, 8'h02, 16'h0100};
    tbl[3] = '{8'h0F, 8'hF0, 16'h0E10};
    tbl[4] = '{8'h00, 8'h77, 16'h0000};
    tbl[5] = '{8'h03, 8'h05, 16'h000F};
    tbl[6] = '{8'hFF, 8'h01, 16'h00FF};
    tbl[7] = '{8'h10, 8'h10, 16'h0100};
    tbl[8] = '{8'h77, 8'h00, 16'h0000};
    tbl[9] = '{8'hA5, 8'h3C, 16'h26AC};

    rst = 1'b1; in_valid = 1'b0; out_ready = 1'b0; a = 8'h00; b = 8'h00;
    h_in_valid = 1'b0; h_out_ready = 1'b0; h_a = 8'h00; h_b = 8'h00;
    repeat (3) @(negedge clk);
    check("rst.out_valid", 32'(out_valid), 32'd0);
    check("rst.out_product", 32'(out_product), 32'd0);
    check("rst.in_ready", 32'(in_ready), 32'd1);
    check("rst.busy", 32'(busy), 32'd0);
    rst = 1'b0;

    // out_ready in IDLE must not create a result
    out_ready = 1'b1;
    repeat (2) @(negedge clk);
    check("idle.out_ready", 32'(out_valid), 32'd0);
    out_ready = 1'b0;

    for (int i = 0; i < 10; i++)
      run_op($sformatf("tbl%0d", i), tbl[i].a, tbl[i].b, tbl[i].p, i % 3, 1'b0);

    // backpressure with an ignored in_valid pulse during the stall
    run_op("bp", 8'hA5, 8'h3C, 16'h26AC, 6, 1'b1);
    for (int i = 0; i < 6; i++) begin
      @(negedge clk);
      check("bp.no_ghost_valid", 32'(out_valid), 32'd0);
      check("bp.no_ghost_busy", 32'(busy), 32'd0);
    end

    // reset at the step-2 edge (third edge after accept)
    in_valid = 1'b1; a = 8'hFF; b = 8'hFF; out_ready = 1'b1;
    @(negedge clk);
    in_valid = 1'b0;
    check("rstmid.busy", 32'(busy), 32'd1);
    repeat (2) @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    out_ready = 1'b0;
    check("rstmid.out_valid", 32'(out_valid), 32'd0);
    check("rstmid.out_product", 32'(out_product), 32'd0);
    check("rstmid.in_ready", 32'(in_ready), 32'd1);
    check("rstmid.busy", 32'(busy), 32'd0);
    run_op("rstmid.after", 8'h03, 8'h05, 16'h000F, 0, 1'b0);

    // random operands against plain multiplication
    for (int i = 0; i < 40; i++) begin
      rx = 8'($urandom);
      ry = 8'($urandom);
      if (i % 10 == 3) rx = 8'h00;
      if (i % 10 == 7) ry = 8'hFF;
      run_op($sformatf("rnd%0d", i), rx, ry, 16'(rx) * 16'(ry), int'($urandom_range(0, 3)), 1'b0);
    end

    // HOLD_LAST=0: back-to-back with clear on handshake
    @(negedge clk);
    h_in_valid = 1'b1; h_a = 8'h10; h_b = 8'h10; h_out_ready = 1'b1;
    @(negedge clk);
    h_in_valid = 1'b0;
    check("h0.calc_prod", 32'(h_out_product), 32'd0);
    k = 0;
    while (!h_out_valid && k < 20) begin @(negedge clk); k++; end
    check("h0.lat1", 32'(k), 32'd4);
    check("h0.prod1", 32'(h_out_product), 32'h0100);
    @(negedge clk);
    check("h0.hs_valid", 32'(h_out_valid), 32'd0);
    check("h0.hs_clear", 32'(h_out_product), 32'd0);
    check("h0.hs_inrdy", 32'(h_in_ready), 32'd1);
    h_in_valid = 1'b1; h_a = 8'h02; h_b = 8'h03;
    @(negedge clk);
    h_in_valid = 1'b0;
    check("h0.accept2", 32'(h_busy), 32'd1);
    k = 0;
    while (!h_out_valid && k < 20) begin
      check("h0.gap_zero", 32'(h_out_product), 32'd0);
      @(negedge clk); k++;
    end
    check("h0.lat2", 32'(k), 32'd4);
    check("h0.prod2", 32'(h_out_product), 32'h0006);
    @(negedge clk);
    h_out_ready = 1'b0;
    check("h0.hs2_clear", 32'(h_out_product), 32'd0);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule
